// File: rtl/sfifo_rd_stream.sv
// sfifo_rd_stream: drains an sfifo through a credit-limited skid buffer into a valid/ready stream.
// Define SFIFO_RD_STREAM_CNT_EN to build the 16-bit accepted-word counter port xfer_cnt.
module sfifo_rd_stream #(
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_r_en,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
`ifdef SFIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]   xfer_cnt
`endif
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + RD_LAT + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [RD_LAT-1:0] inflight;
  logic [DW-1:0]     buf_q [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     inflight_cnt;
  logic [CW-1:0]     credit;
  logic              capture;
  logic              pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + CW'(inflight[i]);
    end
  end

  // Credit counts buffered words plus reads still travelling through the FIFO's read pipe.
  assign credit    = occ + inflight_cnt;
  assign fifo_r_en = en & ~fifo_empty & (credit < CW'(DEPTH));
  assign capture   = inflight[RD_LAT-1];
  assign m_valid   = (occ != '0);
  assign pop       = m_valid & m_ready;
  assign m_data    = buf_q[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else begin
      inflight <= (inflight << 1) | RD_LAT'(fifo_r_en);
      if (capture) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + CW'(capture) - CW'(pop);
    end
  end

  // NOTE: the skid buffer is reset, unlike a RAM, so m_data is defined as 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (capture) begin
      buf_q[wr_ptr] <= fifo_dout;
    end
  end

`ifdef SFIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt <= '0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Self-checking bench for sfifo_rd_stream: behavioural sfifo model, stream monitor, scenario tasks.
`timescale 1ns/1ps
module tb_sfifo_rd_stream;

  localparam int DW     = 8;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = RD_LAT + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_r_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef SFIFO_RD_STREAM_CNT_EN
  logic [15:0]   xfer_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, issued = 0, popped = 0, valid_cyc = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_pend[$];
  logic [DW-1:0] got_q[$];
  int            pop_cyc[$];
  logic          hold_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;

  always #5 clk = ~clk;

  sfifo_rd_stream #(.DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef SFIFO_RD_STREAM_CNT_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  // sfifo model: one-cycle registered read, empty flag updated at the same edge as the read.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q.delete();
      wr_pend.delete();
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      if (fifo_r_en) begin
        n_tests++;
        if (fifo_q.size() == 0) begin
          n_fail++;
          $display("FAIL underflow: r_en=1 with model fifo empty at cycle %0d (required r_en=0)", cyc);
        end else begin
          fifo_dout <= fifo_q.pop_front();
        end
      end
      while (wr_pend.size() > 0) fifo_q.push_back(wr_pend.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Stream monitor: inputs change just after posedge, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      if (fifo_r_en) issued++;
      if (m_valid)   valid_cyc++;
      if (hold_prev) begin
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== data_prev) begin
          n_fail++;
          $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", m_valid, m_data, data_prev);
        end
      end
      hold_prev = m_valid & ~m_ready;
      data_prev = m_data;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        pop_cyc.push_back(cyc);
        popped++;
      end
      n_tests++;
      if (issued - popped > DEPTH) begin
        n_fail++;
        $display("FAIL credit: %0d words outstanding, required at most %0d", issued - popped, DEPTH);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog expired");
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_book();
    got_q.delete();
    pop_cyc.delete();
    issued = 0;
    popped = 0;
    valid_cyc = 0;
  endtask

  task automatic wait_got(int n, int budget, string name);
    for (int i = 0; i < budget && got_q.size() < n; i++) step();
    n_tests++;
    if (got_q.size() < n) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d words, required %0d", name, got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    step(2);
    n_tests++;
    if (fifo_r_en !== 1'b0) begin n_fail++; $display("FAIL reset_r_en: got %b, required 0", fifo_r_en); end
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", m_valid); end
    n_tests++;
    if (m_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 00", m_data); end
`ifdef SFIFO_RD_STREAM_CNT_EN
    n_tests++;
    if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d, required 0", xfer_cnt); end
`endif
    #3 rst = 1'b1;
    step();
    clear_book();
  endtask

  task automatic test_basic();
    clear_book();
    en = 1'b1;
    m_ready = 1'b1;
    wr_pend.push_back(8'h75);
    wr_pend.push_back(8'h76);
    wr_pend.push_back(8'h77);
    wait_got(3, 30, "basic");
    step(4);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== DW'(8'h75 + i)) begin
        n_fail++;
        $display("FAIL basic_data[%0d]: got %h, required %h", i, got_q[i], DW'(8'h75 + i));
      end
      n_tests++;
      if (pop_cyc[i] !== pop_cyc[0] + i) begin
        n_fail++;
        $display("FAIL basic_gap[%0d]: popped at cycle %0d, required %0d", i, pop_cyc[i], pop_cyc[0] + i);
      end
    end
    n_tests++;
    if (issued !== 3) begin n_fail++; $display("FAIL basic_reads: got %0d r_en pulses, required 3", issued); end
  endtask

  task automatic test_backpressure();
    clear_book();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr_pend.push_back(DW'(8'h75 + i));
    step(12);
    sample();
    n_tests++;
    if (issued !== DEPTH) begin n_fail++; $display("FAIL bp_reads: got %0d r_en pulses, required %0d", issued, DEPTH); end
    n_tests++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, required 1", m_valid); end
    n_tests++;
    if (m_data !== 8'h75) begin n_fail++; $display("FAIL bp_data: got %h, required 75", m_data); end
    step();
    m_ready = 1'b1;
    wait_got(8, 40, "bp_drain");
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== DW'(8'h75 + i) || pop_cyc[i] !== pop_cyc[0] + i) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: got %h at cycle %0d, required %h at cycle %0d",
                 i, got_q[i], pop_cyc[i], DW'(8'h75 + i), pop_cyc[0] + i);
      end
    end
    step(4);
    n_tests++;
    if (issued !== 8) begin n_fail++; $display("FAIL bp_total: got %0d r_en pulses, required 8", issued); end
  endtask

  task automatic test_single();
    step(3);
    clear_book();
    m_ready = 1'b1;
    wr_pend.push_back(8'h78);
    wait_got(1, 20, "single");
    step(5);
    n_tests++;
    if (issued !== 1) begin n_fail++; $display("FAIL single_reads: got %0d, required 1", issued); end
    n_tests++;
    if (valid_cyc !== 1) begin n_fail++; $display("FAIL single_valid: %0d valid cycles, required 1", valid_cyc); end
    n_tests++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h78) begin
      n_fail++;
      $display("FAIL single_data: got %0d words first %h, required 1 word 78", got_q.size(), got_q[0]);
    end
  endtask

  task automatic test_random();
    int k;
    rst = 1'b0;
    #4 rst = 1'b1;
    step();
    clear_book();
    en = 1'b1;
    for (int i = 0; i < 64; i++) wr_pend.push_back(DW'(i));
    k = 0;
    while (k < 2000 && got_q.size() < 64) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    m_ready = 1'b1;
    step(6);
    n_tests++;
    if (got_q.size() !== 64) begin n_fail++; $display("FAIL rand_count: got %0d words, required 64", got_q.size()); end
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== DW'(i)) begin n_fail++; $display("FAIL rand_data[%0d]: got %h, required %h", i, got_q[i], DW'(i)); end
    end
`ifdef SFIFO_RD_STREAM_CNT_EN
    n_tests++;
    if (xfer_cnt !== 16'd64) begin n_fail++; $display("FAIL rand_cnt: got %0d, required 64", xfer_cnt); end
`endif
  endtask

  task automatic test_en();
    clear_book();
    en = 1'b0;
    m_ready = 1'b1;
    wr_pend.push_back(8'h75);
    wr_pend.push_back(8'h76);
    for (int i = 0; i < 6; i++) begin
      sample();
      n_tests++;
      if (fifo_r_en !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL en_off: r_en=%b valid=%b, required both 0", fifo_r_en, m_valid);
      end
    end
    step();
    en = 1'b1;
    sample();
    n_tests++;
    if (fifo_r_en !== 1'b1) begin n_fail++; $display("FAIL en_on_r_en: got %b, required 1", fifo_r_en); end
    sample();
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL en_lat_early: valid=%b one edge after issue, required 0", m_valid); end
    sample();
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 8'h75) begin
      n_fail++;
      $display("FAIL en_lat: valid=%b data=%h two edges after issue, required 1 and 75", m_valid, m_data);
    end
    wait_got(2, 20, "en_drain");
    n_tests++;
    if (got_q.size() < 2 || got_q[0] !== 8'h75 || got_q[1] !== 8'h76) begin
      n_fail++;
      $display("FAIL en_order: got %0d words, required 75,76", got_q.size());
    end
  endtask

  task automatic test_rst_mid();
    clear_book();
    en = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr_pend.push_back(DW'(8'hA0 + i));
    step(8);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_tests++;
    if (m_valid !== 1'b1 || fifo_r_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: valid=%b r_en=%b, required both 1", m_valid, fifo_r_en);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (m_valid !== 1'b0 || fifo_r_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: valid=%b r_en=%b, required both 0", m_valid, fifo_r_en);
    end
    step(2);
    #2 rst = 1'b1;
    step(4);
    n_tests++;
    if (m_valid !== 1'b0 || fifo_r_en !== 1'b0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL rst_idle: valid=%b r_en=%b data=%h, required 0 0 00", m_valid, fifo_r_en, m_data);
    end
`ifdef SFIFO_RD_STREAM_CNT_EN
    n_tests++;
    if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d, required 0", xfer_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_random();
    test_en();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sfifo_rd_stream.md
# sfifo_rd_stream

Read-side drain stage placed directly downstream of `sfifo`. It issues `r_en` pulses into the FIFO, absorbs the FIFO's fixed read latency in an internal skid buffer, and presents the data as a valid/ready stream to the consumer. Words are never lost under consumer backpressure, and the block never reads an empty FIFO, so `sfifo` underflow cannot occur.

## Interface
- `DW`, 8: data width, matches `sfifo` `din`/`dout`.
- `RD_LAT`, 1: FIFO read latency in clocks. `dout` is sampled `RD_LAT` edges after the edge that sampled `r_en` high.
- `DEPTH`, `RD_LAT+2` (localparam): skid buffer entries; sized for one word per cycle sustained.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  drain enable; 0 stops new reads, in-flight words still land.
- `fifo_empty`  in  1  `sfifo` `empty`, registered, reflects reads at the same edge.
- `fifo_dout`  in  DW  `sfifo` `dout`.
- `fifo_r_en`  out  1  `sfifo` `r_en`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts when `m_valid & m_ready` at an edge.
- `m_data`  out  DW  output word, held stable while `m_valid & !m_ready`.
- `xfer_cnt`  out  16  accepted-word counter (only with `SFIFO_RD_STREAM_CNT_EN`).

## Operation
- State: `RD_LAT`-bit in-flight shift register `inflight`; circular buffer `DEPTH`×DW with `wr_ptr`, `rd_ptr`, `occ` (0..DEPTH); `credit = occ + popcount(inflight)`.
- `fifo_r_en = en & !fifo_empty & (credit < DEPTH)`. Function of registered state and `fifo_empty` only; no combinational path from `m_ready`.
- Each edge: `inflight` shifts in `fifo_r_en`. When the bit leaving `inflight` is 1, `fifo_dout` is written at `wr_ptr`, `wr_ptr` advances.
- Pop when `m_valid & m_ready`: `rd_ptr` advances.
- `occ` next = `occ` + capture − pop. Simultaneous capture and pop leaves `occ` unchanged. Pointers wrap modulo `DEPTH`.
- `m_valid = (occ != 0)`, `m_data = buf[rd_ptr]`. There is no bypass: a captured word appears the cycle after capture.
- Ordering is strict FIFO. Credit accounting guarantees no capture when `occ == DEPTH`; if that condition ever occurs, it is a design error and the bench flags it.
- `en` deassert mid-stream: already-issued reads complete, and the buffer drains to the consumer normally.

## Timing
- Reset (`rst`=0, async): `fifo_r_en`=0, `m_valid`=0, `m_data`=0, `occ`=0, pointers 0, `inflight`=0, `xfer_cnt`=0. Reset mid-operation discards buffered and in-flight words; `sfifo` shares `rst`, so this is consistent.
- First word: `fifo_r_en` high before edge E0 → captured at E(RD_LAT) → `m_valid` high after E(RD_LAT). With `RD_LAT`=1, `m_valid` rises two edges after the first read is issued.
- Sustained throughput: one word/cycle with `m_ready`=1 and FIFO non-empty.
- Backpressure: with `m_ready`=0, at most `DEPTH` words are issued in total; `fifo_r_en` then stays 0 until a pop frees credit, and reads resume the cycle after that pop.
- FIFO with 1 word: exactly one `fifo_r_en` pulse, because `fifo_empty` rises at the same edge.

## Configuration
- `SFIFO_RD_STREAM_CNT_EN` defined: port `xfer_cnt` exists. It increments on every pop, wraps 0xFFFF→0, and resets to 0.
- Undefined: `xfer_cnt` port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, write 0x75,0x76,0x77 into `sfifo`, `m_ready`=1 → `m_data` sequence 0x75,0x76,0x77 on consecutive valid cycles; `fifo_r_en` exactly 3 pulses; `sfifo` underflow never asserts.
- Write 0x75..0x7C, hold `m_ready`=0 → exactly `DEPTH`(3) `fifo_r_en` pulses, `m_valid`=1, `m_data`=0x75 stable. Release `m_ready` → 0x75..0x7C in order, with no gaps after the first word.
- Single word 0x78 written after idle → one `fifo_r_en` pulse, `m_valid` high for exactly one cycle with `m_ready`=1, `m_data`=0x78.
- Random `m_ready` (50%) over 64 incrementing words from 0x00 → output 0x00..0x3F in order, no drop or duplicate; with the macro defined, `xfer_cnt`=64.
- `en`=0 with FIFO non-empty → `fifo_r_en` stays 0, `m_valid` stays 0; `en`=1 → first word 0x75 appears `RD_LAT`+1 edges later.
- Assert `rst` mid-stream with 2 words buffered → `m_valid`=0 and `fifo_r_en`=0 immediately (asynchronously); after release the block is idle and `xfer_cnt`=0.
